// File: rtl/csr_latch_pkg.sv
// rtl/csr_latch_pkg.sv - shared constants and command decode for the gated SR latch bank
//
// Purpose: input encoding, reset values and the per-bit command decode used by
//          csr_latch and csr_latch_bit.
// Ports:   none (package).
package csr_latch_pkg;

  // S and R are active-low: 0 requests the action, 1 leaves the bit alone.
  localparam logic ASSERTED = 1'b0;
  localparam logic IDLE     = 1'b1;

  // Reset values.
  localparam logic RST_Q       = 1'b0;
  localparam logic RST_QBAR    = 1'b1;
  localparam logic RST_STORED  = 1'b0;
  localparam logic RST_ILLEGAL = 1'b0;
  localparam logic RST_GATE    = 1'b0;

  typedef enum logic [1:0] {
    BIT_HOLD,
    BIT_SET,
    BIT_RESET,
    BIT_FORBID
  } bit_cmd_e;

  // Closed gate holds every bit, so S/R only matter while c is high.
  function automatic bit_cmd_e decode_cmd(input logic c, input logic s, input logic r);
    bit_cmd_e cmd;
    cmd = BIT_HOLD;
    if (c) begin
      if (s == ASSERTED && r == ASSERTED) cmd = BIT_FORBID;
      else if (s == ASSERTED)             cmd = BIT_SET;
      else if (r == ASSERTED)             cmd = BIT_RESET;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/csr_latch_bit.sv
// rtl/csr_latch_bit.sv - one bit of the gated SR latch bank
//
// Purpose: holds the stored bit, detects the forbidden S=R=0 case and
//          produces registered Q/Qbar with NAND-style forbidden outputs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   c_i, s_i, r_i   : gate and active-low set/reset (already synchronized)
//   q_o, qbar_o     : registered true/complement outputs
//   forbid_o        : current inputs form the forbidden combination
module csr_latch_bit
  import csr_latch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic c_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic qbar_o,
  output logic forbid_o
);

  bit_cmd_e cmd;
  logic     stored_q, stored_d;
  logic     q_q, q_d;
  logic     qbar_q, qbar_d;

  always_comb begin
    cmd      = decode_cmd(c_i, s_i, r_i);
    stored_d = stored_q;
    case (cmd)
      BIT_SET:   stored_d = 1'b1;
      BIT_RESET: stored_d = 1'b0;
      default:   stored_d = stored_q;
    endcase
    // Outside the forbidden case the outputs always reflect the stored bit,
    // which is what makes leaving the forbidden state deterministic.
    q_d    = stored_d;
    qbar_d = ~stored_d;
    if (cmd == BIT_FORBID) begin
      q_d    = 1'b1;
      qbar_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_q <= RST_STORED;
      q_q      <= RST_Q;
      qbar_q   <= RST_QBAR;
    end else begin
      stored_q <= stored_d;
      q_q      <= q_d;
      qbar_q   <= qbar_d;
    end
  end

  assign q_o      = q_q;
  assign qbar_o   = qbar_q;
  assign forbid_o = (cmd == BIT_FORBID);

endmodule

// File: rtl/csr_latch.sv
// rtl/csr_latch.sv - bank of clocked SR latches with optional input synchronizer
//
// Purpose: WIDTH gated SR latch bits sharing one gate, with a sticky flag for
//          the forbidden S=R=0 combination.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   C            : shared gate (1 = transparent, 0 = hold)
//   S, R         : active-low set/reset per bit
//   illegal_clr  : synchronous clear of illegal
//   Q, Qbar      : latch outputs
//   illegal      : sticky forbidden-condition flag
// SYNC_STAGES must be 0, 2 or 3.
module csr_latch
  import csr_latch_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             C,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             illegal
);

  localparam int VW = 2 * WIDTH + 1;
  localparam logic [VW-1:0] SYNC_IDLE = {RST_GATE, {WIDTH{IDLE}}, {WIDTH{IDLE}}};

  logic [VW-1:0]    raw_in;
  logic [VW-1:0]    synced;
  logic             c_s;
  logic [WIDTH-1:0] s_s, r_s;
  logic [WIDTH-1:0] forbid;
  logic             illegal_q, illegal_d;

  assign raw_in = {C, S, R};

  // C, S and R share one chain so they stay aligned through the synchronizer.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = raw_in;
    end else begin : g_sync
      logic [VW-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
        end else begin
          sync_q[0] <= raw_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign c_s = synced[VW-1];
  assign s_s = synced[2*WIDTH-1:WIDTH];
  assign r_s = synced[WIDTH-1:0];

  generate
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      csr_latch_bit u_bit (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_i      (c_s),
        .s_i      (s_s[b]),
        .r_i      (r_s[b]),
        .q_o      (Q[b]),
        .qbar_o   (Qbar[b]),
        .forbid_o (forbid[b])
      );
    end
  endgenerate

  // A new forbidden event outranks a simultaneous clear.
  always_comb begin
    illegal_d = illegal_q;
    if (|forbid)          illegal_d = 1'b1;
    else if (illegal_clr) illegal_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= RST_ILLEGAL;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_csr_latch.sv
// tb/tb_csr_latch.sv - scoreboard bench for csr_latch (WIDTH=1/SYNC=0 and WIDTH=4/SYNC=2)
module tb_csr_latch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] s = 4'hF;
  logic [3:0] r = 4'hF;

  logic       q0, qb0, ill0;
  logic [3:0] q2, qb2;
  logic       ill2;

  always #5 clk = ~clk;

  csr_latch #(.WIDTH(1), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .C(c), .S(s[0]), .R(r[0]),
    .illegal_clr(clr), .Q(q0), .Qbar(qb0), .illegal(ill0)
  );

  csr_latch #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .C(c), .S(s), .R(r),
    .illegal_clr(clr), .Q(q2), .Qbar(qb2), .illegal(ill2)
  );

  typedef struct packed {
    logic       q0;
    logic       qb0;
    logic       ill0;
    logic [3:0] q2;
    logic [3:0] qb2;
    logic       ill2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: stored bits, sticky flags, and the input history seen
  // by the 2-stage synchronized bank (inputs act SYNC_STAGES edges late).
  logic [3:0] m_st0, m_st2;
  logic       m_ill0, m_ill2;
  logic [8:0] m_pipe[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st0  = 4'h0;
    m_st2  = 4'h0;
    m_ill0 = 1'b0;
    m_ill2 = 1'b0;
    m_pipe = {};
    repeat (2) m_pipe.push_back({1'b0, 4'hF, 4'hF});
  endtask

  // Latch rules applied to the low w bits for one clock edge.
  task automatic apply(input logic cc, input logic [3:0] ss, input logic [3:0] rr,
                       input int w, input logic cl,
                       inout logic [3:0] st, inout logic ill,
                       output logic [3:0] q, output logic [3:0] qb);
    logic any;
    any = 1'b0;
    q   = 4'h0;
    qb  = 4'h0;
    for (int i = 0; i < w; i++) begin
      if (cc && !ss[i] && !rr[i]) begin
        q[i]  = 1'b1;
        qb[i] = 1'b1;
        any   = 1'b1;
      end else begin
        if (cc && !ss[i])      st[i] = 1'b1;
        else if (cc && !rr[i]) st[i] = 1'b0;
        q[i]  = st[i];
        qb[i] = !st[i];
      end
    end
    if (any)     ill = 1'b1;
    else if (cl) ill = 1'b0;
  endtask

  task automatic step(input logic cc, input logic [3:0] ss, input logic [3:0] rr, input logic cl);
    logic [3:0] q, qb;
    logic [8:0] eff;
    exp_t       e;
    @(negedge clk);
    c   = cc;
    s   = ss;
    r   = rr;
    clr = cl;
    apply(cc, ss, rr, 1, cl, m_st0, m_ill0, q, qb);
    e.q0   = q[0];
    e.qb0  = qb[0];
    e.ill0 = m_ill0;
    eff = m_pipe.pop_front();
    m_pipe.push_back({cc, ss, rr});
    apply(eff[8], eff[7:4], eff[3:0], 4, cl, m_st2, m_ill2, q, qb);
    e.q2   = q;
    e.qb2  = qb;
    e.ill2 = m_ill2;
    sb.push_back(e);
  endtask

  // Async reset with C=1, S=0 driven; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    c   = 1'b1;
    s   = 4'h0;
    r   = 4'hF;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q0", q0, 1'b0);
    chk("rst_qb0", qb0, 1'b1);
    chk("rst_ill0", ill0, 1'b0);
    chk("rst_q2", q2, 4'h0);
    chk("rst_qb2", qb2, 4'hF);
    chk("rst_ill2", ill2, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_hold_q0", q0, 1'b0);
    chk("rst_hold_q2", q2, 4'h0);
    @(negedge clk);
    c     = 1'b0;
    s     = 4'hF;
    r     = 4'hF;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every cycle the banks present outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q0", q0, e.q0);
        chk("qbar0", qb0, e.qb0);
        chk("illegal0", ill0, e.ill0);
        chk("q2", q2, e.q2);
        chk("qbar2", qb2, e.qb2);
        chk("illegal2", ill2, e.ill2);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       cc, cl;
    logic [3:0] ss, rr;
    model_reset();
    do_reset();

    // Gated set/reset: C 10 cycles high / 10 low, inputs change every 5 cycles.
    repeat (5)  step(1'b1, 4'h0, 4'hF, 1'b0);
    repeat (5)  step(1'b1, 4'hF, 4'hF, 1'b0);
    repeat (10) step(1'b0, 4'hF, 4'h0, 1'b0);
    repeat (5)  step(1'b1, 4'hF, 4'h0, 1'b0);

    // Hold after a set.
    step(1'b1, 4'h0, 4'hF, 1'b0);
    repeat (10) step(1'b1, 4'hF, 4'hF, 1'b0);

    // Forbidden from stored 0, release both, then clear the flag.
    repeat (3) step(1'b1, 4'hF, 4'h0, 1'b0);
    repeat (4) step(1'b1, 4'h0, 4'h0, 1'b0);
    repeat (4) step(1'b1, 4'hF, 4'hF, 1'b0);
    step(1'b1, 4'hF, 4'hF, 1'b1);
    repeat (3) step(1'b1, 4'hF, 4'hF, 1'b0);

    // Forbidden inputs with the gate closed.
    repeat (5) step(1'b0, 4'h0, 4'h0, 1'b0);

    // Set wins over a simultaneous clear; single-input release.
    repeat (3) step(1'b1, 4'h0, 4'h0, 1'b1);
    repeat (3) step(1'b1, 4'h0, 4'hF, 1'b1);
    repeat (3) step(1'b1, 4'h0, 4'h0, 1'b0);
    repeat (3) step(1'b0, 4'h0, 4'h0, 1'b0);

    // Latency and width on the synchronized bank.
    do_reset();
    repeat (5) step(1'b1, 4'b1010, 4'b0101, 1'b0);
    repeat (3) step(1'b0, 4'hF, 4'hF, 1'b0);

    // Randomized traffic, including resets during forbidden periods.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cc = ($urandom_range(0, 3) != 0);
        ss = 4'($urandom);
        rr = 4'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          ss = 4'hF;
          rr = 4'hF;
        end
        cl = ($urandom_range(0, 7) == 0);
        step(cc, ss, rr, cl);
      end
    end
    step(1'b0, 4'hF, 4'hF, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
